// File: rtl/delay_pkg.sv
// Shared definitions for the delay-path measurement blocks: sequencer state
// encoding, expected settled level of a path, and a saturating counter step.
package delay_pkg;

    // Burst sequencer states, one pass through PREP..EVAL per trial.
    typedef enum logic [2:0] {
        IDLE,
        PREP,
        LAUNCH,
        WAIT,
        EVAL,
        FINISH
    } seqState_t;

    // Level the path output settles to after a rising launch edge.
    function automatic logic expected_level(input int pathInverts);
        return 1'b1 ^ (pathInverts != 0);
    endfunction

    // Increment that sticks at the all-ones value of a width-bit counter.
    // Callers pass their counter zero-extended to 32 bits (width <= 32).
    function automatic logic [31:0] satIncrement(input logic [31:0] value,
                                                 input int unsigned width);
        logic [31:0] maxValue;
        maxValue = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (value >= maxValue) ? maxValue : value + 32'd1;
    endfunction

endpackage

// File: rtl/delay_path_sequencer_if.sv
// Host-side request/result bundle of the delay path sequencer.
// The host drives the master modport; the sequencer implements the slave.
interface delay_path_sequencer_if #(
    parameter int CNT_W = 16,
    parameter int DLY_W = 8
);
    logic             start;
    logic [CNT_W-1:0] trials;
    logic [DLY_W-1:0] sample_delay;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pass_count;
    logic [CNT_W-1:0] fail_count;

    modport master (
        output start, trials, sample_delay,
        input  busy, done, pass_count, fail_count
    );

    modport slave (
        input  start, trials, sample_delay,
        output busy, done, pass_count, fail_count
    );
endinterface

// File: rtl/delay_path_capture.sv
// Two-flop sampler for the asynchronous delay-path output. cap1 loads only on
// the capture strobe; cap2 re-times it one edge later to resolve metastability.
// Both flops must stay discrete registers so the first stage sits at the path.
module delay_path_capture
    import delay_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic captureStrobe,
    input  logic pathResult,
    output logic capturedLevel
);

    (* shreg_extract = "no", async_reg = "true" *) logic cap1;
    (* shreg_extract = "no", async_reg = "true" *) logic cap2;

    // Sample the path on the strobe, then pass the sample through the second stage.
    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignment so cap2 takes the pre-edge cap1.
        if (rst) begin
            cap1 <= 1'b0;
            cap2 <= 1'b0;
        end else begin
            if (captureStrobe) begin
                cap1 <= pathResult;
            end
            cap2 <= cap1;
        end
    end

    assign capturedLevel = cap2;

endmodule

// File: rtl/delay_path_sequencer.sv
// Burst sequencer for one inverter-chain delay path. For each trial it holds
// the path input low to settle, launches a rising edge, captures the path
// output D cycles later and scores the trial as pass or fail.
module delay_path_sequencer
    import delay_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int DLY_W         = 8,
    parameter int SETTLE_CYCLES = 8,
    parameter int PATH_INVERTS  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    delay_path_sequencer_if.slave   host,
    output logic                    pathInput,
    input  logic                    pathResult
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic EXPECTED = expected_level(PATH_INVERTS);

    seqState_t        state;
    seqState_t        nextState;
    logic [CNT_W-1:0] trialsLeft;
    logic [DLY_W-1:0] delayReg;
    logic [DLY_W-1:0] waitCnt;
    logic [SET_W-1:0] settleCnt;
    logic [CNT_W-1:0] passCount;
    logic [CNT_W-1:0] failCount;
    logic             captureStrobe;
    logic             capturedLevel;

    delay_path_capture u_capture (
        .clk           (clk),
        .rst           (rst),
        .captureStrobe (captureStrobe),
        .pathResult    (pathResult),
        .capturedLevel (capturedLevel)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode and capture strobe timing.
    always_comb begin
        // NOTE: every output gets a default first, so no branch can infer a latch.
        nextState     = state;
        captureStrobe = 1'b0;
        unique case (state)
            IDLE: begin
                if (host.start) begin
                    nextState = (host.trials == '0) ? FINISH : PREP;
                end
            end
            PREP: begin
                if (settleCnt == '0) begin
                    nextState = LAUNCH;
                end
            end
            LAUNCH: begin
                nextState = WAIT;
            end
            WAIT: begin
                // waitCnt runs D..0; the D-th WAIT cycle ends on edge E0+D.
                captureStrobe = (waitCnt == DLY_W'(1));
                if (waitCnt == '0) begin
                    nextState = EVAL;
                end
            end
            EVAL: begin
                nextState = (trialsLeft == CNT_W'(1)) ? FINISH : PREP;
            end
            FINISH: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Burst bookkeeping: request latch, settle/wait timers, launch level, scores.
    always_ff @(posedge clk) begin
        if (rst) begin
            trialsLeft <= '0;
            delayReg   <= '0;
            waitCnt    <= '0;
            settleCnt  <= '0;
            passCount  <= '0;
            failCount  <= '0;
            pathInput  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (host.start) begin
                        trialsLeft <= host.trials;
                        delayReg   <= (host.sample_delay == '0) ? DLY_W'(1)
                                                                : host.sample_delay;
                        passCount  <= '0;
                        failCount  <= '0;
                        settleCnt  <= SETTLE_LAST;
                    end
                end
                PREP: begin
                    if (settleCnt != '0) begin
                        settleCnt <= settleCnt - SET_W'(1);
                    end
                end
                LAUNCH: begin
                    waitCnt   <= delayReg;
                    pathInput <= 1'b1;
                end
                WAIT: begin
                    if (waitCnt != '0) begin
                        waitCnt <= waitCnt - DLY_W'(1);
                    end
                end
                EVAL: begin
                    pathInput  <= 1'b0;
                    trialsLeft <= trialsLeft - CNT_W'(1);
                    settleCnt  <= SETTLE_LAST;
                    if (capturedLevel == EXPECTED) begin
                        passCount <= CNT_W'(satIncrement(32'(passCount), CNT_W));
                    end else begin
                        failCount <= CNT_W'(satIncrement(32'(failCount), CNT_W));
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign host.busy       = (state == PREP) || (state == LAUNCH) ||
                             (state == WAIT) || (state == EVAL);
    assign host.done       = (state == FINISH);
    assign host.pass_count = passCount;
    assign host.fail_count = failCount;

endmodule
